mc_ctrl_fsm: RTL and testbench
==============================

MC_CTRL_FSM -- requirements
Module: mc_ctrl_fsm

Interface
REQ-001 Parameter OP_W, default 6: opcode width.
REQ-002 Parameter FUNCT_W, default 6: R-type function field width.
REQ-003 Parameter ALUOP_W, default 6: ALU operation code width driven to the ALU.
REQ-004 Parameter HAS_JAL, default 1: 1 enables JAL decode; 0 treats JAL as illegal.
REQ-005 Parameter TIMEOUT, default 15: maximum consecutive memory-wait cycles before trap; 0 disables the timeout.
REQ-006 The block SHALL have one clock; reset is synchronous and active-high.
REQ-007 Ports, in order:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- opcode  in  OP_W  IR[31:26]
- funct  in  FUNCT_W  IR[5:0]
- alu_zero  in  1  ALU result == 0
- alu_ov  in  1  ALU signed overflow
- mem_ready  in  1  memory completes the current request this cycle
- mem_req  out  1  memory request
- mem_we  out  1  store
- iord  out  1  0 = PC address, 1 = ALUOut address
- ir_write, pc_write, reg_write  out  1 each  register enables
- pc_src  out  2  0 = ALU, 1 = ALUOut, 2 = jump target
- alu_src_a  out  1  0 = PC, 1 = A
- alu_src_b  out  2  0 = B, 1 = 4, 2 = sign-extended imm, 3 = imm<<2
- alu_op  out  ALUOP_W  ALU function
- reg_dst  out  2  0 = rt, 1 = rd, 2 = r31
- mem_to_reg  out  2  0 = ALUOut, 1 = MDR, 2 = PC
- state  out  4  current state encoding
- retire  out  1  one-cycle pulse per completed instruction
- trap  out  1  sticky error flag
- trap_cause  out  2  0 = none, 1 = illegal, 2 = overflow, 3 = timeout

Function
REQ-008 The FSM SHALL have states FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADR, MEM_RD, MEM_WR, WB_MEM, WB_ALU, BRANCH, JUMP, TRAP.
REQ-009 FETCH: mem_req=1, iord=0, alu_src_a=0, alu_src_b=1, alu_op=ADD; when mem_ready=1, ir_write=1, pc_write=1, pc_src=0, and the next state is DECODE; otherwise the FSM stays in FETCH with no enables asserted.
REQ-010 DECODE: alu_src_a=0, alu_src_b=3, alu_op=ADD (precomputes the branch target); next state by opcode: 0x00 -> EXEC_R; 0x08/0x0D -> EXEC_I; 0x23/0x2B -> MEM_ADR; 0x04 -> BRANCH; 0x02, or 0x03 with HAS_JAL=1 -> JUMP; any other opcode -> TRAP with cause 1.
REQ-011 EXEC_R: alu_src_a=1, alu_src_b=0, alu_op taken from funct (0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x2A SLT); any other funct -> TRAP cause 1; ADD/SUB with alu_ov=1 -> TRAP cause 2; otherwise -> WB_ALU with reg_dst=1.
REQ-012 EXEC_I: alu_src_a=1, alu_src_b=2, alu_op=ADD for 0x08 and OR for 0x0D; 0x08 with alu_ov=1 -> TRAP cause 2; otherwise -> WB_ALU with reg_dst=0.
REQ-013 WB_ALU: reg_write=1, mem_to_reg=0, retire=1; next state FETCH.
REQ-014 MEM_ADR: alu_src_a=1, alu_src_b=2, alu_op=ADD; next state MEM_RD for 0x23, MEM_WR for 0x2B.
REQ-015 MEM_RD/MEM_WR: mem_req=1, iord=1, mem_we=1 only in MEM_WR; the FSM holds until mem_ready; on completion MEM_RD -> WB_MEM, and MEM_WR -> FETCH with retire=1.
REQ-016 WB_MEM: reg_write=1, mem_to_reg=1, reg_dst=0, retire=1; next state FETCH.
REQ-017 BRANCH: alu_src_a=1, alu_src_b=0, alu_op=SUB, pc_src=1, pc_write=alu_zero, retire=1; next state FETCH.
REQ-018 JUMP: pc_write=1, pc_src=2, retire=1; for JAL also reg_write=1, reg_dst=2, mem_to_reg=2; next state FETCH.
REQ-019 Wait counter: increments each cycle mem_req=1 and mem_ready=0, and clears on mem_ready or on leaving the wait state; when TIMEOUT>0 and the count reaches TIMEOUT, the next state is TRAP with cause 3.
REQ-020 TRAP: all enables 0, mem_req=0, trap=1, cause held; the FSM remains in TRAP until reset.
REQ-021 mem_ready=1 outside a request state SHALL be ignored.
REQ-022 The block SHALL never assert pc_write and reg_write from an overflowing instruction.

Reset
REQ-023 On reset: state=FETCH, wait counter=0, trap=0, trap_cause=0, retire=0; reset dominates every other input, including while in a wait state or in TRAP.

Structure
REQ-024 A shared package mc_pkg SHALL hold the state encodings, opcode/funct constants, ALU op codes, and trap cause codes.
REQ-025 One sub-module, mc_alu_dec (funct -> alu_op plus legal flag), SHALL be used; everything else is flat.

Verification
REQ-026 add (op 0x00, funct 0x20), mem_ready tied 1 -> states FETCH, DECODE, EXEC_R, WB_ALU, retire pulses after 4 cycles.
REQ-027 lw with mem_ready low for 3 cycles in MEM_RD -> MEM_RD held 4 cycles, WB_MEM follows, completing in 8 cycles total.
REQ-028 beq with alu_zero=0 -> pc_write=0 in BRANCH; with alu_zero=1 -> pc_write=1 and pc_src=1.
REQ-029 opcode 0x3F -> TRAP with cause 1 after DECODE; TRAP persists 20 cycles; reset returns the FSM to FETCH.
REQ-030 TIMEOUT=15 with mem_ready held 0 in FETCH -> TRAP with cause 3 after 15 wait cycles; TIMEOUT=0 -> the FSM waits indefinitely.
REQ-031 add with alu_ov=1 -> TRAP cause 2, reg_write never asserted; HAS_JAL=0 with op 0x03 -> TRAP cause 1.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle controller: states, opcode/funct
// constants, ALU operation codes and trap causes.
package mc_pkg;

  typedef enum logic [3:0] {
    ST_FETCH   = 4'd0,
    ST_DECODE  = 4'd1,
    ST_EXEC_R  = 4'd2,
    ST_EXEC_I  = 4'd3,
    ST_MEM_ADR = 4'd4,
    ST_MEM_RD  = 4'd5,
    ST_MEM_WR  = 4'd6,
    ST_WB_MEM  = 4'd7,
    ST_WB_ALU  = 4'd8,
    ST_BRANCH  = 4'd9,
    ST_JUMP    = 4'd10,
    ST_TRAP    = 4'd11
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'd0,
    CAUSE_ILLEGAL  = 2'd1,
    CAUSE_OVERFLOW = 2'd2,
    CAUSE_TIMEOUT  = 2'd3
  } cause_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_SLT = 4'd4;

endpackage

// File: rtl/mc_ctrl_fsm_alu_dec.sv
// R-type function decoder: maps funct to an ALU operation, flags unknown
// functs, and marks the ops whose signed overflow must trap.
module mc_alu_dec
  import mc_pkg::*;
#(
  parameter int FUNCT_W = 6,
  parameter int ALUOP_W = 6
) (
  input  logic [FUNCT_W-1:0] funct,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               legal,
  output logic               ov_trap
);

  always_comb begin
    alu_op  = ALUOP_W'(ALU_ADD);
    legal   = 1'b1;
    ov_trap = 1'b0;
    case (funct)
      FUNCT_W'(FN_ADD): ov_trap = 1'b1;
      FUNCT_W'(FN_SUB): begin alu_op = ALUOP_W'(ALU_SUB); ov_trap = 1'b1; end
      FUNCT_W'(FN_AND): alu_op = ALUOP_W'(ALU_AND);
      FUNCT_W'(FN_OR):  alu_op = ALUOP_W'(ALU_OR);
      FUNCT_W'(FN_SLT): alu_op = ALUOP_W'(ALU_SLT);
      default:          legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle CPU control FSM with a memory-wait watchdog and sticky trap.
//   state   | meaning
//   FETCH   | read instruction, PC+4 on completion
//   DECODE  | precompute branch target, dispatch on opcode
//   EXEC_R  | R-type ALU op          EXEC_I  | addi / ori
//   MEM_ADR | load/store address     MEM_RD/WR | data access, waits on mem_ready
//   WB_MEM  | load writeback         WB_ALU  | ALU writeback
//   BRANCH  | beq compare            JUMP    | j / jal
//   TRAP    | halted until reset, cause held
module mc_ctrl_fsm
  import mc_pkg::*;
#(
  parameter int OP_W    = 6,
  parameter int FUNCT_W = 6,
  parameter int ALUOP_W = 6,
  parameter int HAS_JAL = 1,
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [OP_W-1:0]    opcode,
  input  logic [FUNCT_W-1:0] funct,
  input  logic               alu_zero,
  input  logic               alu_ov,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               mem_we,
  output logic               iord,
  output logic               ir_write,
  output logic               pc_write,
  output logic               reg_write,
  output logic [1:0]         pc_src,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [ALUOP_W-1:0] alu_op,
  output logic [1:0]         reg_dst,
  output logic [1:0]         mem_to_reg,
  output logic [3:0]         state,
  output logic               retire,
  output logic               trap,
  output logic [1:0]         trap_cause
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  // Count value seen on the last tolerated wait cycle.
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  state_t             state_q, state_d;
  cause_t             cause_q, cause_d;
  logic [CNT_W-1:0]   wait_q, wait_d;
  logic [ALUOP_W-1:0] r_alu_op;
  logic               r_legal, r_ov_trap;
  logic               is_rtype, is_jal;

  mc_alu_dec #(.FUNCT_W(FUNCT_W), .ALUOP_W(ALUOP_W)) u_alu_dec (
    .funct  (funct),
    .alu_op (r_alu_op),
    .legal  (r_legal),
    .ov_trap(r_ov_trap)
  );

  // IR is only loaded in FETCH, so opcode stays valid for the whole instruction.
  assign is_rtype = (opcode == OP_W'(OP_RTYPE));
  assign is_jal   = (HAS_JAL != 0) && (opcode == OP_W'(OP_JAL));

  always_comb begin
    state_d    = state_q;
    cause_d    = cause_q;
    wait_d     = wait_q;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    pc_src     = 2'd0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'd0;
    alu_op     = ALUOP_W'(ALU_ADD);
    reg_dst    = 2'd0;
    mem_to_reg = 2'd0;
    retire     = 1'b0;
    trap       = 1'b0;

    case (state_q)
      ST_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = 2'd1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = ST_DECODE;
        end
      end
      ST_DECODE: begin
        alu_src_b = 2'd3;
        if (is_rtype)
          state_d = ST_EXEC_R;
        else if (opcode == OP_W'(OP_ADDI) || opcode == OP_W'(OP_ORI))
          state_d = ST_EXEC_I;
        else if (opcode == OP_W'(OP_LW) || opcode == OP_W'(OP_SW))
          state_d = ST_MEM_ADR;
        else if (opcode == OP_W'(OP_BEQ))
          state_d = ST_BRANCH;
        else if (opcode == OP_W'(OP_J) || is_jal)
          state_d = ST_JUMP;
        else begin
          state_d = ST_TRAP;
          cause_d = CAUSE_ILLEGAL;
        end
      end
      ST_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = r_alu_op;
        if (!r_legal) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_ILLEGAL;
        end else if (r_ov_trap && alu_ov) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_OVERFLOW;
        end else begin
          reg_dst = 2'd1;
          state_d = ST_WB_ALU;
        end
      end
      ST_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        if (opcode == OP_W'(OP_ORI))
          alu_op = ALUOP_W'(ALU_OR);
        if (opcode == OP_W'(OP_ADDI) && alu_ov) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_OVERFLOW;
        end else
          state_d = ST_WB_ALU;
      end
      ST_WB_ALU: begin
        reg_write = 1'b1;
        reg_dst   = is_rtype ? 2'd1 : 2'd0;
        retire    = 1'b1;
        state_d   = ST_FETCH;
      end
      ST_MEM_ADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        state_d   = (opcode == OP_W'(OP_SW)) ? ST_MEM_WR : ST_MEM_RD;
      end
      ST_MEM_RD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ready)
          state_d = ST_WB_MEM;
      end
      ST_MEM_WR: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        mem_we  = 1'b1;
        if (mem_ready) begin
          retire  = 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 2'd1;
        retire     = 1'b1;
        state_d    = ST_FETCH;
      end
      ST_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_W'(ALU_SUB);
        pc_src    = 2'd1;
        pc_write  = alu_zero;
        retire    = 1'b1;
        state_d   = ST_FETCH;
      end
      ST_JUMP: begin
        pc_write = 1'b1;
        pc_src   = 2'd2;
        retire   = 1'b1;
        if (is_jal) begin
          reg_write  = 1'b1;
          reg_dst    = 2'd2;
          mem_to_reg = 2'd2;
        end
        state_d = ST_FETCH;
      end
      ST_TRAP: trap = 1'b1;
      default: state_d = ST_FETCH;
    endcase

    if (mem_req && !mem_ready) begin
      if (TIMEOUT > 0 && wait_q == CNT_LAST) begin
        state_d = ST_TRAP;
        cause_d = CAUSE_TIMEOUT;
        wait_d  = '0;
      end else
        wait_d = wait_q + 1'b1;
    end else
      wait_d = '0;

    // Reset cycle: nothing may be written, requested or retired.
    if (reset) begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      reg_write = 1'b0;
      retire    = 1'b0;
      trap      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_FETCH;
      cause_q <= CAUSE_NONE;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      wait_q  <= wait_d;
    end
  end

  assign state      = state_q;
  assign trap_cause = cause_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Randomized bench for mc_ctrl_fsm: an instruction-level model expands each
// instruction into its expected per-cycle trace, which is replayed and compared.
module tb_mc_ctrl_fsm;
  import mc_pkg::*;

  typedef struct packed {
    logic [3:0] st;
    logic       mem_req, mem_we, iord, ir_write, pc_write, reg_write, retire, trap;
    logic [1:0] cause, pc_src;
    logic       a;
    logic [1:0] b;
    logic [5:0] op;
    logic [1:0] reg_dst, m2r;
  } obs_t;

  // -1 in an expected field means "not defined in this cycle".
  typedef struct {
    int st, rst, rdy, op_in, fn_in, z_in, ov_in;
    int mem_req, mem_we, iord, ir_write, pc_write, reg_write, retire, trap, cause;
    int pc_src, a, b, op, reg_dst, m2r;
  } cyc_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = '0, funct = '0;
  logic       alu_zero = 1'b0, alu_ov = 1'b0, mem_ready = 1'b0;

  logic       mem_req0, mem_we0, iord0, ir_write0, pc_write0, reg_write0, alu_src_a0, retire0, trap0;
  logic [1:0] pc_src0, alu_src_b0, reg_dst0, mem_to_reg0, trap_cause0;
  logic [5:0] alu_op0;
  logic [3:0] state0;
  logic       mem_req1, mem_we1, iord1, ir_write1, pc_write1, reg_write1, alu_src_a1, retire1, trap1;
  logic [1:0] pc_src1, alu_src_b1, reg_dst1, mem_to_reg1, trap_cause1;
  logic [5:0] alu_op1;
  logic [3:0] state1;

  obs_t o0, o1, o;
  int   sel = 0;
  int   errors = 0, checks = 0, cyc_n = 0;
  int   has_jal_m = 1, tmo_m = 15;
  int   cur_op, cur_fn, cur_z, cur_ov;
  cyc_t q[$];

  always #5 clk = ~clk;

  mc_ctrl_fsm dut0 (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .alu_zero(alu_zero),
    .alu_ov(alu_ov), .mem_ready(mem_ready), .mem_req(mem_req0), .mem_we(mem_we0),
    .iord(iord0), .ir_write(ir_write0), .pc_write(pc_write0), .reg_write(reg_write0),
    .pc_src(pc_src0), .alu_src_a(alu_src_a0), .alu_src_b(alu_src_b0), .alu_op(alu_op0),
    .reg_dst(reg_dst0), .mem_to_reg(mem_to_reg0), .state(state0), .retire(retire0),
    .trap(trap0), .trap_cause(trap_cause0)
  );

  mc_ctrl_fsm #(.HAS_JAL(0), .TIMEOUT(0)) dut1 (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .alu_zero(alu_zero),
    .alu_ov(alu_ov), .mem_ready(mem_ready), .mem_req(mem_req1), .mem_we(mem_we1),
    .iord(iord1), .ir_write(ir_write1), .pc_write(pc_write1), .reg_write(reg_write1),
    .pc_src(pc_src1), .alu_src_a(alu_src_a1), .alu_src_b(alu_src_b1), .alu_op(alu_op1),
    .reg_dst(reg_dst1), .mem_to_reg(mem_to_reg1), .state(state1), .retire(retire1),
    .trap(trap1), .trap_cause(trap_cause1)
  );

  assign o0 = {state0, mem_req0, mem_we0, iord0, ir_write0, pc_write0, reg_write0, retire0,
               trap0, trap_cause0, pc_src0, alu_src_a0, alu_src_b0, alu_op0, reg_dst0, mem_to_reg0};
  assign o1 = {state1, mem_req1, mem_we1, iord1, ir_write1, pc_write1, reg_write1, retire1,
               trap1, trap_cause1, pc_src1, alu_src_a1, alu_src_b1, alu_op1, reg_dst1, mem_to_reg1};
  assign o  = (sel == 0) ? o0 : o1;

  task automatic check(input string tag, input logic [31:0] got, input int exp);
    checks++;
    if (got !== exp[31:0]) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (dut%0d cycle %0d)", tag, got, exp, sel, cyc_n);
    end
  endtask

  function automatic cyc_t cyc(input int st);
    cyc_t c;
    c.st = st; c.rst = 0; c.rdy = int'($urandom_range(0, 1));
    c.op_in = cur_op; c.fn_in = cur_fn; c.z_in = cur_z; c.ov_in = cur_ov;
    c.mem_req = 0; c.mem_we = 0; c.iord = -1; c.ir_write = 0; c.pc_write = 0;
    c.reg_write = 0; c.retire = 0; c.trap = 0; c.cause = 0;
    c.pc_src = -1; c.a = -1; c.b = -1; c.op = -1; c.reg_dst = -1; c.m2r = -1;
    return c;
  endfunction

  function automatic cyc_t req(input int st, input bit fetch, input bit wr);
    cyc_t c;
    c = cyc(st);
    c.mem_req = 1; c.iord = fetch ? 0 : 1; c.mem_we = wr;
    if (fetch) begin c.a = 0; c.b = 1; c.op = int'(ALU_ADD); end
    return c;
  endfunction

  task automatic push_reset();
    cyc_t c;
    c = cyc(-1); c.rst = 1; c.cause = -1;
    q.push_back(c);
  endtask

  task automatic trap_seq(input int cause, input int n);
    cyc_t c;
    for (int i = 0; i < n; i++) begin
      c = cyc(int'(ST_TRAP)); c.trap = 1; c.cause = cause;
      q.push_back(c);
    end
    push_reset();
  endtask

  // A request either finishes after `waits` stalled cycles or trips the watchdog.
  task automatic mem_phase(input int st, input int waits, input bit fetch, input bit wr,
                           output bit tripped);
    cyc_t c;
    int   n;
    tripped = (tmo_m > 0) && (waits >= tmo_m);
    n = tripped ? tmo_m : waits;
    for (int i = 0; i < n; i++) begin
      c = req(st, fetch, wr); c.rdy = 0;
      q.push_back(c);
    end
    if (tripped) trap_seq(3, 4);
    else begin
      c = req(st, fetch, wr); c.rdy = 1;
      if (fetch) begin c.ir_write = 1; c.pc_write = 1; c.pc_src = 0; end
      if (wr) c.retire = 1;
      q.push_back(c);
    end
  endtask

  task automatic wb_alu(input int rd);
    cyc_t c;
    c = cyc(int'(ST_WB_ALU)); c.reg_write = 1; c.m2r = 0; c.retire = 1; c.reg_dst = rd;
    q.push_back(c);
  endtask

  task automatic model_instr(input int op, input int fn, input int z, input int ov,
                             input int wf, input int wm);
    cyc_t c;
    bit   tr, legal, ovc;
    int   alu;
    cur_op = op; cur_fn = fn; cur_z = z; cur_ov = ov;
    mem_phase(int'(ST_FETCH), wf, 1'b1, 1'b0, tr);
    if (tr) return;
    c = cyc(int'(ST_DECODE)); c.a = 0; c.b = 3; c.op = int'(ALU_ADD);
    q.push_back(c);
    if (op == 'h00) begin
      legal = 1; ovc = 0; alu = -1;
      case (fn)
        'h20: begin alu = int'(ALU_ADD); ovc = 1; end
        'h22: begin alu = int'(ALU_SUB); ovc = 1; end
        'h24: alu = int'(ALU_AND);
        'h25: alu = int'(ALU_OR);
        'h2A: alu = int'(ALU_SLT);
        default: legal = 0;
      endcase
      c = cyc(int'(ST_EXEC_R)); c.a = 1; c.b = 0; c.op = alu;
      if (!legal) begin q.push_back(c); trap_seq(1, 20); end
      else if (ovc && ov != 0) begin q.push_back(c); trap_seq(2, 20); end
      else begin c.reg_dst = 1; q.push_back(c); wb_alu(1); end
    end else if (op == 'h08 || op == 'h0D) begin
      c = cyc(int'(ST_EXEC_I)); c.a = 1; c.b = 2;
      c.op = (op == 'h0D) ? int'(ALU_OR) : int'(ALU_ADD);
      q.push_back(c);
      if (op == 'h08 && ov != 0) trap_seq(2, 20);
      else wb_alu(0);
    end else if (op == 'h23 || op == 'h2B) begin
      c = cyc(int'(ST_MEM_ADR)); c.a = 1; c.b = 2; c.op = int'(ALU_ADD);
      q.push_back(c);
      if (op == 'h2B) mem_phase(int'(ST_MEM_WR), wm, 1'b0, 1'b1, tr);
      else begin
        mem_phase(int'(ST_MEM_RD), wm, 1'b0, 1'b0, tr);
        if (!tr) begin
          c = cyc(int'(ST_WB_MEM)); c.reg_write = 1; c.m2r = 1; c.reg_dst = 0; c.retire = 1;
          q.push_back(c);
        end
      end
    end else if (op == 'h04) begin
      c = cyc(int'(ST_BRANCH)); c.a = 1; c.b = 0; c.op = int'(ALU_SUB);
      c.pc_src = 1; c.pc_write = z; c.retire = 1;
      q.push_back(c);
    end else if (op == 'h02 || (op == 'h03 && has_jal_m != 0)) begin
      c = cyc(int'(ST_JUMP)); c.pc_write = 1; c.pc_src = 2; c.retire = 1;
      if (op == 'h03) begin c.reg_write = 1; c.reg_dst = 2; c.m2r = 2; end
      q.push_back(c);
    end else
      trap_seq(1, 20);
  endtask

  task automatic compare(input cyc_t c);
    if (c.st >= 0) check("state", 32'(o.st), c.st);
    check("mem_req", 32'(o.mem_req), c.mem_req);
    check("mem_we", 32'(o.mem_we), c.mem_we);
    if (c.iord >= 0) check("iord", 32'(o.iord), c.iord);
    check("ir_write", 32'(o.ir_write), c.ir_write);
    check("pc_write", 32'(o.pc_write), c.pc_write);
    check("reg_write", 32'(o.reg_write), c.reg_write);
    check("retire", 32'(o.retire), c.retire);
    check("trap", 32'(o.trap), c.trap);
    if (c.cause >= 0) check("trap_cause", 32'(o.cause), c.cause);
    if (c.pc_src >= 0) check("pc_src", 32'(o.pc_src), c.pc_src);
    if (c.a >= 0) check("alu_src_a", 32'(o.a), c.a);
    if (c.b >= 0) check("alu_src_b", 32'(o.b), c.b);
    if (c.op >= 0) check("alu_op", 32'(o.op), c.op);
    if (c.reg_dst >= 0) check("reg_dst", 32'(o.reg_dst), c.reg_dst);
    if (c.m2r >= 0) check("mem_to_reg", 32'(o.m2r), c.m2r);
  endtask

  task automatic run_q();
    cyc_t c;
    while (q.size() > 0) begin
      c = q.pop_front();
      @(negedge clk);
      reset     = (c.rst != 0);
      mem_ready = (c.rdy != 0);
      opcode    = 6'(c.op_in);
      funct     = 6'(c.fn_in);
      alu_zero  = (c.z_in != 0);
      alu_ov    = (c.ov_in != 0);
      #1;
      cyc_n++;
      compare(c);
    end
  endtask

  task automatic do_instr(input int op, input int fn, input int z, input int ov,
                          input int wf, input int wm);
    model_instr(op, fn, z, ov, wf, wm);
    run_q();
  endtask

  task automatic rand_instr(input int maxw);
    int k, op, fn, wf, wm;
    int fns[5] = '{'h20, 'h22, 'h24, 'h25, 'h2A};
    k  = int'($urandom_range(0, 10));
    fn = fns[$urandom_range(0, 4)];
    case (k)
      0, 1: op = 'h00;
      2:    begin op = 'h00; fn = int'($urandom_range(0, 63)); end
      3:    op = 'h08;
      4:    op = 'h0D;
      5:    op = 'h23;
      6:    op = 'h2B;
      7:    op = 'h04;
      8:    op = 'h02;
      9:    op = 'h03;
      default: op = int'($urandom_range(0, 63));
    endcase
    wf = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, maxw)) : int'($urandom_range(0, 3));
    wm = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, maxw)) : int'($urandom_range(0, 3));
    do_instr(op, fn, int'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0) ? 1 : 0, wf, wm);
  endtask

  initial begin
    cyc_t c;
    cur_op = 0; cur_fn = 0; cur_z = 0; cur_ov = 0;

    // Default build: HAS_JAL=1, TIMEOUT=15.
    push_reset(); push_reset(); run_q();
    do_instr('h00, 'h20, 0, 0, 0, 0);   // add, four cycles to retire
    do_instr('h23, 0, 0, 0, 0, 3);      // lw with three stalled cycles
    do_instr('h2B, 0, 0, 0, 1, 2);      // sw
    do_instr('h04, 0, 0, 0, 0, 0);      // beq not taken
    do_instr('h04, 0, 1, 0, 0, 0);      // beq taken
    do_instr('h02, 0, 0, 0, 0, 0);      // j
    do_instr('h03, 0, 0, 0, 0, 0);      // jal
    do_instr('h0D, 0, 0, 1, 0, 0);      // ori ignores overflow
    do_instr('h08, 0, 0, 1, 0, 0);      // addi overflow trap
    do_instr('h3F, 0, 0, 0, 0, 0);      // illegal opcode
    do_instr('h00, 'h20, 0, 1, 0, 0);   // add overflow trap
    do_instr('h00, 'h22, 0, 0, 14, 0);  // longest tolerated fetch stall
    do_instr('h00, 'h20, 0, 0, 15, 0);  // fetch watchdog
    do_instr('h23, 0, 0, 0, 0, 20);     // load watchdog

    // Reset in the middle of a stalled fetch must also clear the wait count.
    cur_op = 'h00; cur_fn = 'h20; cur_z = 0; cur_ov = 0;
    for (int i = 0; i < 10; i++) begin
      c = req(int'(ST_FETCH), 1'b1, 1'b0); c.rdy = 0;
      q.push_back(c);
    end
    push_reset();
    run_q();
    do_instr('h00, 'h20, 0, 0, 10, 0);

    for (int i = 0; i < 150; i++) rand_instr(20);

    // HAS_JAL=0, TIMEOUT=0 build.
    sel = 1; has_jal_m = 0; tmo_m = 0;
    push_reset(); run_q();
    do_instr('h03, 0, 0, 0, 0, 0);      // jal is illegal here
    do_instr('h00, 'h25, 0, 0, 40, 0);  // no watchdog on fetch
    do_instr('h23, 0, 0, 0, 0, 30);     // no watchdog on load
    for (int i = 0; i < 60; i++) rand_instr(40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
